// File: rtl/ptw_mem_arbiter.sv
// Page-table-walk memory arbiter: captures single-cycle read requests from
// NUM_REQ MMUs, grants them round-robin and runs one read at a time over a
// valid/ready memory port. Data and a one-cycle completion pulse go back to
// the owner. An optional watchdog completes a stuck read with an error.
module ptw_mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_pulse,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            resp_ready,
   output logic [NUM_REQ-1:0]            resp_err,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output logic [ADDR_WIDTH-1:0]         mem_req_addr,
   input  logic                          mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]         mem_resp_data,
   input  logic                          mem_resp_err,
   output logic                          busy,
   output logic [GW-1:0]                 grant_id,
   output logic                          proto_err
);

   // Watchdog counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int TW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DRAIN
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [NUM_REQ-1:0]      pend;
   logic [ADDR_WIDTH-1:0]   addr_q [NUM_REQ];
   logic [GW-1:0]           rr_last;
   logic [GW-1:0]           sel_id;
   logic [GW-1:0]           cand;
   logic [NUM_REQ-1:0]      grant_mask;
   logic [TW-1:0]           tmo_cnt;
   logic                    tmo_hit;
   logic                    grant_en;
   logic                    done_en;
   logic                    tmo_en;

   assign tmo_hit = (TIMEOUT_CYCLES > 0) && (tmo_cnt == TW'(TMO_LAST));

   // Round-robin pick: first pending port after rr_last, wrapping.
   always_comb begin
      // NOTE: every comb output gets a default before any branch, so no latch is inferred.
      sel_id = '0;
      cand   = '0;
      // Walk from farthest to nearest so the nearest pending port is written last and wins.
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = GW'((int'(rr_last) + k) % NUM_REQ);
         if (pend[cand]) begin
            sel_id = cand;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the per-cycle control strobes driving the datapath.
   always_comb begin
      state_next    = state;
      grant_en      = 1'b0;
      done_en       = 1'b0;
      tmo_en        = 1'b0;
      grant_mask    = '0;
      mem_req_valid = (state == ST_ISSUE);
      busy          = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            // mem_resp_valid is deliberately ignored here (late or stray response).
            if (|pend) begin
               grant_en           = 1'b1;
               grant_mask[sel_id] = 1'b1;
               state_next         = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (tmo_hit) begin
               tmo_en = 1'b1;
               // If memory accepts in the very cycle we give up, a response is
               // still coming and must be swallowed.
               state_next = mem_req_ready ? ST_DRAIN : ST_IDLE;
            end else if (mem_req_ready) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Completion takes priority over a coincident timeout.
            if (mem_resp_valid) begin
               done_en    = 1'b1;
               state_next = ST_IDLE;
            end else if (tmo_hit) begin
               tmo_en     = 1'b1;
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (mem_resp_valid) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Pending flags: set by an accepted pulse, cleared on grant; drops are sticky errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= '0;
         proto_err <= 1'b0;
      end else begin
         pend <= (pend & ~grant_mask) | (req_pulse & ~pend);
         if (|(req_pulse & pend)) begin
            proto_err <= 1'b1;
         end
      end
   end

   // Per-port address capture, only when the pulse is accepted.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
      // NOTE: address storage is qualified by pend, so it needs no reset.
      always_ff @(posedge clk) begin
         if (req_pulse[g] && !pend[g]) begin
            addr_q[g] <= req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   // Grant bookkeeping, memory address and watchdog counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_id     <= '0;
         mem_req_addr <= '0;
         rr_last      <= GW'(NUM_REQ - 1);
         tmo_cnt      <= '0;
      end else begin
         if (grant_en) begin
            grant_id     <= sel_id;
            mem_req_addr <= addr_q[sel_id];
            tmo_cnt      <= '0;
         end else if ((TIMEOUT_CYCLES > 0) && (state == ST_ISSUE || state == ST_WAIT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
         if (done_en || tmo_en) begin
            rr_last <= grant_id;
         end
      end
   end

   // Completion pulse to the owner; resp_data holds until the next completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_ready <= '0;
         resp_err   <= '0;
         resp_data  <= '0;
      end else begin
         resp_ready <= '0;
         resp_err   <= '0;
         if (done_en) begin
            resp_ready[grant_id] <= 1'b1;
            resp_err[grant_id]   <= mem_resp_err;
            resp_data            <= mem_resp_data;
         end else if (tmo_en) begin
            resp_ready[grant_id] <= 1'b1;
            resp_err[grant_id]   <= 1'b1;
            resp_data            <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Self-checking bench for ptw_mem_arbiter (2 requesters, 16-cycle watchdog).
// Expected memory addresses and completions are queued when requests are
// driven and compared by a monitor when the DUT handshakes or pulses resp_ready.
module tb_ptw_mem_arbiter;

   typedef struct {
      logic [1:0]  ready;
      logic [1:0]  err;
      logic [31:0] data;
   } resp_t;

   logic        clk;
   logic        rst;
   logic [1:0]  req_pulse;
   logic [63:0] req_addr;
   logic [1:0]  resp_ready;
   logic [1:0]  resp_err;
   logic [31:0] resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        busy;
   logic [0:0]  grant_id;
   logic        proto_err;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] exp_addr_q[$];
   resp_t       exp_resp_q[$];

   ptw_mem_arbiter #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .NUM_REQ       (2),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_pulse     (req_pulse),
      .req_addr      (req_addr),
      .resp_ready    (resp_ready),
      .resp_err      (resp_err),
      .resp_data     (resp_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data),
      .mem_resp_err  (mem_resp_err),
      .busy          (busy),
      .grant_id      (grant_id),
      .proto_err     (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents model; the constant makes 0x1004 read back 0xDEAD_BEEF.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return a ^ 32'hDEAD_AEEB;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_mem(input logic [31:0] a);
      exp_addr_q.push_back(a);
   endtask

   task automatic expect_resp(input int port, input logic [31:0] d, input logic e);
      resp_t r;
      r.ready       = 2'b00;
      r.err         = 2'b00;
      r.ready[port] = 1'b1;
      r.err[port]   = e;
      r.data        = d;
      exp_resp_q.push_back(r);
   endtask

   // Pulse the masked ports for one cycle; returns one cycle later.
   task automatic drive_req(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] a1);
      req_pulse = mask;
      req_addr  = {a1, a0};
      step();
      req_pulse = 2'b00;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_resp_ready"}, resp_ready, 0);
      check({tag, "_resp_err"}, resp_err, 0);
      check({tag, "_resp_data"}, resp_data, 0);
      check({tag, "_mem_req_valid"}, mem_req_valid, 0);
      check({tag, "_mem_req_addr"}, mem_req_addr, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_grant_id"}, grant_id, 0);
      check({tag, "_proto_err"}, proto_err, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   // Memory side of one read: wait for the request, stall, accept, answer after lat cycles.
   task automatic serve(input logic [31:0] exp_a, input int stall, input int lat, input logic err);
      int n = 0;
      while (!mem_req_valid && n < 40) begin
         step();
         n++;
      end
      check("issue_seen", mem_req_valid, 1'b1);
      for (int s = 0; s < stall; s++) begin
         check("stall_valid", mem_req_valid, 1'b1);
         check("stall_addr", mem_req_addr, exp_a);
         step();
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      repeat (lat) step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_fn(mem_req_addr);
      mem_resp_err   = err;
      step();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_err   = 1'b0;
   endtask

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req_valid && mem_req_ready) begin
            check("mem_req_expected", exp_addr_q.size() > 0, 1'b1);
            if (exp_addr_q.size() > 0) begin
               check("mem_req_addr", mem_req_addr, exp_addr_q.pop_front());
            end
         end
         if (|resp_ready) begin
            check("resp_expected", exp_resp_q.size() > 0, 1'b1);
            if (exp_resp_q.size() > 0) begin
               resp_t r;
               r = exp_resp_q.pop_front();
               check("sb_resp_ready", resp_ready, r.ready);
               check("sb_resp_err", resp_err, r.err);
               check("sb_resp_data", resp_data, r.data);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      req_pulse      = '0;
      req_addr       = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_err   = 1'b0;
      repeat (3) step();
      check_reset_outputs("rst");
      rst = 1'b0;
      step();

      // 1: single read on port 0, latency and hold
      mem_req_ready = 1'b1;
      expect_mem(32'h0000_1004);
      expect_resp(0, 32'hDEAD_BEEF, 1'b0);
      drive_req(2'b01, 32'h0000_1004, 32'h0);
      check("t1_no_valid_t1", mem_req_valid, 1'b0);
      step();
      check("t1_valid_t2", mem_req_valid, 1'b1);
      check("t1_addr", mem_req_addr, 32'h0000_1004);
      check("t1_busy", busy, 1'b1);
      step();
      mem_req_ready = 1'b0;
      check("t1_valid_drop", mem_req_valid, 1'b0);
      step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_fn(32'h0000_1004);
      step();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      check("t1_resp_ready", resp_ready, 2'b01);
      check("t1_resp_data", resp_data, 32'hDEAD_BEEF);
      check("t1_resp_err", resp_err, 2'b00);
      step();
      check("t1_pulse_width", resp_ready, 2'b00);
      check("t1_data_hold", resp_data, 32'hDEAD_BEEF);
      check("t1_idle", busy, 1'b0);

      // 2: simultaneous requests, round-robin order, memory error on port 1
      do_reset();
      expect_mem(32'h100);
      expect_resp(0, mem_fn(32'h100), 1'b0);
      expect_mem(32'h200);
      expect_resp(1, mem_fn(32'h200), 1'b0);
      drive_req(2'b11, 32'h100, 32'h200);
      serve(32'h100, 0, 2, 1'b0);
      serve(32'h200, 0, 2, 1'b0);
      check("t2_last_owner", grant_id, 1'b1);
      expect_mem(32'h110);
      expect_resp(0, mem_fn(32'h110), 1'b0);
      expect_mem(32'h210);
      expect_resp(1, mem_fn(32'h210), 1'b1);
      drive_req(2'b11, 32'h110, 32'h210);
      serve(32'h110, 0, 1, 1'b0);
      serve(32'h210, 0, 1, 1'b1);
      step();

      // 3: memory stalls the request for 5 cycles
      expect_mem(32'h3008);
      expect_resp(1, mem_fn(32'h3008), 1'b0);
      drive_req(2'b10, 32'h0, 32'h3008);
      serve(32'h3008, 5, 3, 1'b0);
      step();

      // 4: watchdog on withheld data, drain, then a queued request
      expect_mem(32'h4000);
      expect_resp(0, 32'h0, 1'b1);
      drive_req(2'b01, 32'h4000, 32'h0);
      step();
      check("t4_issue", mem_req_valid, 1'b1);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      repeat (14) step();
      check("t4_not_yet", resp_ready, 2'b00);
      step();
      check("t4_tmo_ready", resp_ready, 2'b01);
      check("t4_tmo_err", resp_err, 2'b01);
      check("t4_tmo_data", resp_data, 32'h0);
      check("t4_drain_busy", busy, 1'b1);
      step();
      expect_mem(32'h4100);
      expect_resp(1, mem_fn(32'h4100), 1'b0);
      drive_req(2'b10, 32'h0, 32'h4100);
      repeat (10) step();
      check("t4_drain_no_grant", mem_req_valid, 1'b0);
      check("t4_busy_before", busy, 1'b1);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hBAD0_BAD0;
      step();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      check("t4_discard", resp_ready, 2'b00);
      check("t4_busy_fall", busy, 1'b0);
      check("t4_data_kept", resp_data, 32'h0);
      serve(32'h4100, 0, 1, 1'b0);
      step();

      // 5: second pulse while pending is dropped
      check("t5_proto_clear", proto_err, 1'b0);
      expect_mem(32'h300);
      expect_resp(1, mem_fn(32'h300), 1'b0);
      req_pulse = 2'b10;
      req_addr  = {32'h300, 32'h0};
      step();
      req_addr  = {32'h400, 32'h0};
      step();
      req_pulse = 2'b00;
      check("t5_proto_set", proto_err, 1'b1);
      check("t5_addr", mem_req_addr, 32'h300);
      serve(32'h300, 0, 1, 1'b0);
      repeat (3) step();
      check("t5_proto_sticky", proto_err, 1'b1);
      check("t5_single_read", mem_req_valid, 1'b0);

      // 6: reset while waiting for data; late response is ignored
      expect_mem(32'h600);
      drive_req(2'b01, 32'h600, 32'h0);
      step();
      check("t6_issue", mem_req_valid, 1'b1);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      check("t6_wait_busy", busy, 1'b1);
      step();
      rst = 1'b1;
      step();
      check_reset_outputs("t6");
      rst = 1'b0;
      step();
      step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_fn(32'h600);
      step();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      check("t6_no_pulse", resp_ready, 2'b00);
      check("t6_idle", busy, 1'b0);
      step();
      check("t6_still_idle", mem_req_valid, 1'b0);

      check("sb_addr_empty", exp_addr_q.size(), 0);
      check("sb_resp_empty", exp_resp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
